// File: rtl/scr_test_pkg.sv
// Shared constants for the CHK LE breakdown/BOD test: 50 MHz timing, counter width,
// trigger-generator FSM encoding.
package scr_test_pkg;

    localparam int unsigned CNT_W           = 19;
    localparam int unsigned HALF_PERIOD_50M = 500000;  // 10 ms
    localparam int unsigned PULSE_WIDTH_50M = 500;     // 10 us
    localparam int unsigned MIN_GAP_50M     = 25;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFDelay = 3'd1,
        StFPulse = 3'd2,
        StFRest  = 3'd3,
        StNDelay = 3'd4,
        StNPulse = 3'd5,
        StNRest  = 3'd6
    } scr_state_e;

    function automatic logic [CNT_W-1:0] clamp_delay(input logic [CNT_W-1:0] req,
                                                     input logic [CNT_W-1:0] lim);
        return (req > lim) ? lim : req;
    endfunction

endpackage

// File: rtl/scr_pulse_timer.sv
// Loadable down-counter timing one trigger pulse; o_tc flags the last pulse clock.
module scr_pulse_timer #(
    parameter int unsigned PULSE_WIDTH = 500
) (
    input  logic i_clk_50m,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_tc
);

    localparam int unsigned    TW       = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
    localparam logic [TW-1:0]  LOAD_VAL = TW'(PULSE_WIDTH - 1);

    logic [TW-1:0] count_q;

    always_ff @(posedge i_clk_50m or posedge i_rst) begin
        if (i_rst) begin
            count_q <= '0;
        end else if (i_load) begin
            count_q <= LOAD_VAL;
        end else if (i_en && (count_q != '0)) begin
            count_q <= count_q - TW'(1);
        end
    end

    assign o_tc = (count_q == '0);

endmodule

// File: rtl/scr_trigger_pulse_gen.sv
// Alternating forward/negative SCR trigger pulse generator, one pair per mains cycle,
// with phase delay, burst/continuous runs and immediate inhibit.
module scr_trigger_pulse_gen
    import scr_test_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = HALF_PERIOD_50M,
    parameter int unsigned PULSE_WIDTH = PULSE_WIDTH_50M,
    parameter int unsigned MIN_GAP     = MIN_GAP_50M
) (
    input  logic             i_clk_50m,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_inhibit,
    input  logic [CNT_W-1:0] i_phase_delay,
    input  logic [7:0]       i_burst_count,
    output logic             o_signal_forward,
    output logic             o_signal_negative,
    output logic             o_signal_forbid,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] DELAY_MAX = CNT_W'(HALF_PERIOD - PULSE_WIDTH - MIN_GAP);

    scr_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] delay_q;
    logic [7:0]       cyc_q;
    logic             cont_q;
    logic             stop_req_q;
    logic             start_q;
    logic             fwd_q;
    logic             neg_q;
    logic             forbid_q;
    logic             busy_q;
    logic             done_q;

    logic             start_edge;
    logic             wrap;
    logic             f_half;
    logic             n_half;
    logic             in_delay;
    logic             in_pulse;
    logic             end_run;
    logic             fire;
    logic             pulse_tc;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] delay_new;

    // Decisions look at the count the next clock will show, so a registered pulse is
    // high exactly while the counter reads delay..delay+PULSE_WIDTH-1.
    always_comb begin
        start_edge = i_start & ~start_q;
        wrap       = (cnt_q == CNT_LAST);
        cnt_next   = wrap ? '0 : cnt_q + CNT_W'(1);
        delay_new  = clamp_delay(i_phase_delay, DELAY_MAX);
        f_half     = state_q inside {StFDelay, StFPulse, StFRest};
        n_half     = state_q inside {StNDelay, StNPulse, StNRest};
        in_delay   = state_q inside {StFDelay, StNDelay};
        in_pulse   = state_q inside {StFPulse, StNPulse};
        end_run    = n_half && wrap &&
                     ((!cont_q && (cyc_q == 8'd1)) || stop_req_q || i_stop);
        if (state_q == StIdle) begin
            fire = start_edge && (delay_new == '0);
        end else if (wrap) begin
            fire = !end_run && (delay_new == '0);
        end else begin
            fire = in_delay && (cnt_next == delay_q);
        end
        fire = fire && !i_inhibit;
    end

    scr_pulse_timer #(
        .PULSE_WIDTH (PULSE_WIDTH)
    ) u_pulse_timer (
        .i_clk_50m (i_clk_50m),
        .i_rst     (i_rst),
        .i_load    (fire),
        .i_en      (in_pulse),
        .o_tc      (pulse_tc)
    );

    always_ff @(posedge i_clk_50m or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            delay_q    <= '0;
            cyc_q      <= '0;
            cont_q     <= 1'b0;
            stop_req_q <= 1'b0;
            start_q    <= 1'b1;  // a start level already high at release is not an edge
            fwd_q      <= 1'b0;
            neg_q      <= 1'b0;
            forbid_q   <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            start_q <= i_start;
            done_q  <= 1'b0;
            if (i_inhibit) begin
                state_q    <= StIdle;
                cnt_q      <= '0;
                stop_req_q <= 1'b0;
                fwd_q      <= 1'b0;
                neg_q      <= 1'b0;
                forbid_q   <= 1'b1;
                busy_q     <= 1'b0;
            end else if (state_q == StIdle) begin
                if (start_edge) begin
                    cnt_q      <= '0;
                    delay_q    <= delay_new;
                    cyc_q      <= i_burst_count;
                    cont_q     <= (i_burst_count == 8'd0);
                    stop_req_q <= 1'b0;
                    forbid_q   <= 1'b0;
                    busy_q     <= 1'b1;
                    fwd_q      <= fire;
                    state_q    <= fire ? StFPulse : StFDelay;
                end
            end else begin
                cnt_q      <= cnt_next;
                stop_req_q <= stop_req_q | i_stop;
                if (wrap) begin
                    delay_q <= delay_new;
                    if (f_half) begin
                        fwd_q   <= 1'b0;
                        neg_q   <= fire;
                        state_q <= fire ? StNPulse : StNDelay;
                    end else if (end_run) begin
                        state_q    <= StIdle;
                        cnt_q      <= '0;
                        stop_req_q <= 1'b0;
                        fwd_q      <= 1'b0;
                        neg_q      <= 1'b0;
                        forbid_q   <= 1'b1;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                    end else begin
                        if (!cont_q) begin
                            cyc_q <= cyc_q - 8'd1;
                        end
                        fwd_q   <= fire;
                        neg_q   <= 1'b0;
                        state_q <= fire ? StFPulse : StFDelay;
                    end
                end else begin
                    case (state_q)
                        StFDelay: begin
                            if (fire) begin
                                state_q <= StFPulse;
                                fwd_q   <= 1'b1;
                            end
                        end
                        StNDelay: begin
                            if (fire) begin
                                state_q <= StNPulse;
                                neg_q   <= 1'b1;
                            end
                        end
                        StFPulse: begin
                            if (pulse_tc) begin
                                state_q <= StFRest;
                                fwd_q   <= 1'b0;
                            end
                        end
                        StNPulse: begin
                            if (pulse_tc) begin
                                state_q <= StNRest;
                                neg_q   <= 1'b0;
                            end
                        end
                        StFRest, StNRest: begin
                        end
                        default: begin
                            state_q  <= StIdle;
                            cnt_q    <= '0;
                            fwd_q    <= 1'b0;
                            neg_q    <= 1'b0;
                            forbid_q <= 1'b1;
                            busy_q   <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign o_signal_forward  = fwd_q;
    assign o_signal_negative = neg_q;
    assign o_signal_forbid   = forbid_q;
    assign o_busy            = busy_q;
    assign o_done            = done_q;

endmodule

// File: tb/tb_scr_trigger_pulse_gen.sv
// Bench for scr_trigger_pulse_gen: directed scenarios plus random runs, every cycle
// compared against a run-time based reference model.
module tb_scr_trigger_pulse_gen;

    localparam int unsigned HP   = 100;
    localparam int unsigned PW   = 5;
    localparam int unsigned MG   = 2;
    localparam int unsigned DMAX = HP - PW - MG;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic        inhibit;
    logic [18:0] delay;
    logic [7:0]  burst;
    logic        fwd, neg, forbid, busy, done;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    always #10 clk = ~clk;

    scr_trigger_pulse_gen #(
        .HALF_PERIOD (HP),
        .PULSE_WIDTH (PW),
        .MIN_GAP     (MG)
    ) dut (
        .i_clk_50m         (clk),
        .i_rst             (rst),
        .i_start           (start),
        .i_stop            (stop),
        .i_inhibit         (inhibit),
        .i_phase_delay     (delay),
        .i_burst_count     (burst),
        .o_signal_forward  (fwd),
        .o_signal_negative (neg),
        .o_signal_forbid   (forbid),
        .o_busy            (busy),
        .o_done            (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: run time t since start, half = t / HP, position = t % HP.
    bit          m_active, m_done, m_stop, m_prev_start;
    int unsigned m_t, m_d, m_n;

    function automatic int unsigned clampd(input logic [18:0] d);
        return (int'(d) > int'(DMAX)) ? DMAX : int'(d);
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_active = 0; m_done = 0; m_stop = 0; m_prev_start = 1;
            m_t = 0; m_d = 0; m_n = 0;
        end else begin
            m_done = 0;
            if (inhibit) begin
                m_active = 0;
            end else if (!m_active) begin
                if (start && !m_prev_start) begin
                    m_active = 1; m_t = 0; m_n = burst; m_d = clampd(delay); m_stop = 0;
                end
            end else begin
                if (stop) m_stop = 1;
                m_t++;
                if (m_t % HP == 0) begin
                    if ((m_t % (2 * HP) == 0) &&
                        (m_stop || (m_n != 0 && m_t / (2 * HP) == m_n))) begin
                        m_active = 0;
                        m_done   = 1;
                    end else begin
                        m_d = clampd(delay);
                    end
                end
            end
            m_prev_start = start;
        end
    end

    int fwd_rises = 0, neg_rises = 0, done_cnt = 0, fwd_hi = 0, busy_hi = 0;
    bit fwd_prev = 0, neg_prev = 0;

    initial forever begin
        int unsigned ph;
        bit fh, inp;
        @(negedge clk);
        if (chk_en) begin
            ph  = m_t % HP;
            fh  = ((m_t / HP) % 2) == 0;
            inp = m_active && (ph >= m_d) && (ph < m_d + PW);
            check("busy", busy, m_active);
            check("forbid", forbid, !m_active);
            check("forward", fwd, inp && fh);
            check("negative", neg, inp && !fh);
            check("done", done, m_done);
            check("one_pulse", fwd & neg, 0);
        end
        if (fwd && !fwd_prev) fwd_rises++;
        if (neg && !neg_prev) neg_rises++;
        if (done) done_cnt++;
        if (fwd) fwd_hi++;
        if (busy) busy_hi++;
        fwd_prev = fwd;
        neg_prev = neg;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int k = 0;
        while (busy && k < bound) begin
            @(negedge clk);
            k++;
        end
        check(tag, busy, 0);
    endtask

    initial begin
        int f0, n0, d0, h0, b0, k;
        rst = 1; start = 0; stop = 0; inhibit = 0; delay = '0; burst = '0;
        #35;
        check("rst_forward", fwd, 0);
        check("rst_negative", neg, 0);
        check("rst_forbid", forbid, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        rst = 0;
        chk_en = 1;
        cycles(3);

        // Burst of two cycles
        delay = 10; burst = 2;
        f0 = fwd_rises; n0 = neg_rises; d0 = done_cnt;
        pulse_start();
        wait_idle("burst2_end", 1000);
        cycles(2);
        check("burst2_fwd_pulses", fwd_rises - f0, 2);
        check("burst2_neg_pulses", neg_rises - n0, 2);
        check("burst2_done", done_cnt - d0, 1);
        check("burst2_forbid", forbid, 1);

        // Delay clamp
        delay = 99; burst = 1;
        h0 = fwd_hi;
        pulse_start();
        wait_idle("clamp_end", 1000);
        cycles(2);
        check("clamp_width", fwd_hi - h0, PW);

        // Inhibit on the third clock of a forward pulse
        delay = 20; burst = 3; d0 = done_cnt;
        pulse_start();
        k = 0;
        while (!fwd && k < 400) begin @(negedge clk); k++; end
        check("inh_fwd_seen", fwd, 1);
        cycles(2);
        inhibit = 1;
        cycles(1);
        check("inh_forward", fwd, 0);
        check("inh_forbid", forbid, 1);
        check("inh_busy", busy, 0);
        inhibit = 0;
        cycles(300);
        check("inh_no_restart", busy, 0);
        check("inh_no_done", done_cnt - d0, 0);

        // Stop during the forward rest of the third cycle
        delay = 15; burst = 0;
        f0 = fwd_rises; n0 = neg_rises; d0 = done_cnt;
        pulse_start();
        k = 0;
        while (fwd_rises - f0 < 3 && k < 1000) begin @(negedge clk); k++; end
        check("stop_third_fwd", fwd_rises - f0, 3);
        cycles(PW + 3);
        stop = 1;
        wait_idle("stop_end", 400);
        stop = 0;
        cycles(2);
        check("stop_neg_pulses", neg_rises - n0, 3);
        check("stop_done", done_cnt - d0, 1);

        // Asynchronous reset during a negative pulse
        delay = 30; burst = 2;
        pulse_start();
        k = 0;
        while (!neg && k < 400) begin @(negedge clk); k++; end
        check("rstrun_neg_seen", neg, 1);
        @(posedge clk);
        #3 rst = 1;
        #1;
        check("rstrun_forward", fwd, 0);
        check("rstrun_negative", neg, 0);
        check("rstrun_forbid", forbid, 1);
        check("rstrun_busy", busy, 0);
        cycles(3);
        rst = 0;
        f0 = fwd_rises;
        cycles(300);
        check("rstrun_idle", busy, 0);
        check("rstrun_no_pulse", fwd_rises - f0, 0);

        // Delay 0 with a second start edge mid-run
        delay = 0; burst = 2;
        b0 = busy_hi; d0 = done_cnt;
        pulse_start();
        cycles(50);
        start = 0;
        cycles(1);
        start = 1;
        wait_idle("d0_end", 1000);
        cycles(2);
        check("d0_run_length", busy_hi - b0, 4 * HP);
        check("d0_done", done_cnt - d0, 1);

        // Random runs
        for (int it = 0; it < 6; it++) begin
            delay = 19'($urandom_range(0, 130));
            burst = 8'($urandom_range(0, 3));
            pulse_start();
            for (int c = 0; c < 700; c++) begin
                if ($urandom_range(0, 59) == 0) delay = 19'($urandom_range(0, 130));
                inhibit = ($urandom_range(0, 499) == 0);
                stop    = ($urandom_range(0, 299) == 0);
                if ($urandom_range(0, 199) == 0) start = ~start;
                @(negedge clk);
            end
            inhibit = 0;
            stop = 1;
            wait_idle("rand_end", 500);
            stop = 0;
            cycles(2);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
